// File: rtl/melody_sequencer.sv
// melody_sequencer: programmable melody player driving a PWM audio pin.
// A note RAM holds {dur, oct, pitch} entries. Playback supports start, stop
// and loop control, inserts a silent gap at the end of every note, stops at
// a dur==0 marker and reports status.
// Optional build macro MELODY_VOLUME_EN adds a 4-bit volume input that gates
// the high half-period with a 16-step duty pattern.
module melody_sequencer #(
    parameter int CLK_HZ      = 25000000,
    parameter int DEPTH       = 64,
    parameter int DUR_W       = 4,
    parameter int BEAT_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 250000,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DUR_W+5:0]  wr_data,
`ifdef MELODY_VOLUME_EN
    input  logic [3:0]        volume,
`endif
    output logic              aud_pwm,
    output logic              aud_sd,
    output logic              playing,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_TONE  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    // Half-period numerator; the lowest note (C4) gives the widest count.
    localparam longint CLK500   = longint'(CLK_HZ) * 500;
    localparam int     HALF_W   = $clog2(CLK500 / 261626 + 1);
    localparam longint NOTE_MAX = longint'((1 << DUR_W) - 1) * BEAT_CYCLES;
    localparam int     NOTE_W   = $clog2(NOTE_MAX + 1);
    localparam int     GAP_W    = $clog2(GAP_CYCLES + 1);

    // Every arm is an elaboration-time constant, so this folds into a small ROM.
    function automatic logic [HALF_W-1:0] half_lookup(input logic [3:0] p);
        case (p)
            4'd1:    return HALF_W'(CLK500 / 261626);
            4'd2:    return HALF_W'(CLK500 / 277183);
            4'd3:    return HALF_W'(CLK500 / 293665);
            4'd4:    return HALF_W'(CLK500 / 311127);
            4'd5:    return HALF_W'(CLK500 / 329628);
            4'd6:    return HALF_W'(CLK500 / 349228);
            4'd7:    return HALF_W'(CLK500 / 369994);
            4'd8:    return HALF_W'(CLK500 / 391995);
            4'd9:    return HALF_W'(CLK500 / 415305);
            4'd10:   return HALF_W'(CLK500 / 440000);
            4'd11:   return HALF_W'(CLK500 / 466164);
            4'd12:   return HALF_W'(CLK500 / 493883);
            default: return '0;
        endcase
    endfunction

    logic [DUR_W+5:0]  mem [DEPTH];
    logic [DUR_W+5:0]  fetch_word;
    logic [DUR_W-1:0]  fetch_dur;
    logic [1:0]        fetch_oct;
    logic [3:0]        fetch_pitch;

    logic [2:0]        state;
    logic [NOTE_W-1:0] note_cnt;
    logic [HALF_W-1:0] tone_cnt;
    logic [HALF_W-1:0] half_eff;
    logic [GAP_W-1:0]  gap_cnt;
    logic              is_rest;
    logic              tone_level;

    assign fetch_word  = mem[note_idx];
    assign fetch_dur   = fetch_word[DUR_W+5:6];
    assign fetch_oct   = fetch_word[5:4];
    assign fetch_pitch = fetch_word[3:0];

    // Note RAM write port, open in every state.
    // NOTE: the RAM has no reset; clearing it would forbid block-RAM mapping and
    // a reset must keep the programmed song anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Playback FSM with note, tone and gap counters; status registered with state.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            note_idx   <= '0;
            note_cnt   <= '0;
            tone_cnt   <= '0;
            half_eff   <= '0;
            gap_cnt    <= '0;
            is_rest    <= 1'b0;
            tone_level <= 1'b0;
            playing    <= 1'b0;
            aud_sd     <= 1'b0;
            done       <= 1'b0;
        end else if (stop) begin
            state      <= S_IDLE;
            tone_level <= 1'b0;
            playing    <= 1'b0;
            aud_sd     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        note_idx <= '0;
                        playing  <= 1'b1;
                        aud_sd   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    tone_level <= 1'b0;
                    if (fetch_dur == '0) begin
                        state <= S_END;
                    end else begin
                        state    <= S_TONE;
                        note_cnt <= NOTE_W'(fetch_dur) * NOTE_W'(BEAT_CYCLES)
                                    - NOTE_W'(GAP_CYCLES);
                        tone_cnt <= '0;
                        half_eff <= half_lookup(fetch_pitch) >> fetch_oct;
                        is_rest  <= (fetch_pitch == 4'd0) || (fetch_pitch > 4'd12);
                    end
                end
                S_TONE: begin
                    note_cnt <= note_cnt - NOTE_W'(1);
                    if (note_cnt == NOTE_W'(1)) begin
                        state      <= S_GAP;
                        gap_cnt    <= '0;
                        tone_cnt   <= '0;
                        tone_level <= 1'b0;
                    end else if (!is_rest) begin
                        if (tone_cnt == half_eff - HALF_W'(1)) begin
                            tone_cnt   <= '0;
                            tone_level <= ~tone_level;
                        end else begin
                            tone_cnt <= tone_cnt + HALF_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        if (note_idx == ADDR_W'(DEPTH - 1)) begin
                            state <= S_END;
                        end else begin
                            note_idx <= note_idx + ADDR_W'(1);
                            state    <= S_FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_END: begin
                    if (loop_en) begin
                        note_idx <= '0;
                        state    <= S_FETCH;
                    end else begin
                        done    <= 1'b1;
                        state   <= S_IDLE;
                        playing <= 1'b0;
                        aud_sd  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    playing <= 1'b0;
                    aud_sd  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MELODY_VOLUME_EN
    logic [3:0] vol_cnt;

    // Free-running duty counter that slices the high half-period into 16 steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            vol_cnt <= '0;
        end else begin
            vol_cnt <= vol_cnt + 4'd1;
        end
    end

    assign aud_pwm = tone_level && (vol_cnt < volume);
`else
    assign aud_pwm = tone_level;
`endif

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench for melody_sequencer (default build).
// The reference model walks the song note by note with plain arithmetic and
// queues every expected change of the output tuple with its clock edge; a
// monitor pops and compares whenever the DUT outputs change.
module tb_melody_sequencer;

    localparam int CLK_HZ = 100000;
    localparam int DEPTH  = 8;
    localparam int DUR_W  = 4;
    localparam int BEAT   = 2000;
    localparam int GAP    = 100;
    localparam int ADDR_W = 3;

    typedef struct {
        longint     t;
        logic       pwm;
        logic       play;
        logic       done;
        logic [2:0] idx;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DUR_W+5:0]  wr_data = '0;
    logic              aud_pwm;
    logic              aud_sd;
    logic              playing;
    logic [ADDR_W-1:0] note_idx;
    logic              done;

    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    logic   mon_en = 1'b0;

    ev_t    exp_q[$];
    logic [DUR_W+5:0] ram_img [DEPTH];
    longint freq_mhz [12] = '{261626, 277183, 293665, 311127, 329628, 349228,
                              369994, 391995, 415305, 440000, 466164, 493883};

    // Model's view of the output tuple and the cut-off edge for stop/reset.
    logic   m_pwm = 1'b0;
    logic   m_play = 1'b0;
    logic   m_done = 1'b0;
    int     m_idx = 0;
    longint m_cut = 64'h7fff_ffff_ffff_ffff;
    longint m_end = 0;

    melody_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .DEPTH       (DEPTH),
        .DUR_W       (DUR_W),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .aud_pwm  (aud_pwm),
        .aud_sd   (aud_sd),
        .playing  (playing),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    function automatic longint half_ref(input int p);
        if (p < 1 || p > 12) return 0;
        return longint'(CLK_HZ) * 500 / freq_mhz[p-1];
    endfunction

    function automatic logic [DUR_W+5:0] ent(input int dur, input int oct, input int pitch);
        return {4'(dur), 2'(oct), 4'(pitch)};
    endfunction

    // Queue an expected tuple at edge t if it differs from the previous one.
    task automatic emit(input longint t, input logic pwm, input logic play,
                        input int idx, input logic dn);
        ev_t e;
        if (t >= m_cut) return;
        if (pwm == m_pwm && play == m_play && idx == m_idx && dn == m_done) return;
        e.t = t; e.pwm = pwm; e.play = play; e.done = dn; e.idx = 3'(idx);
        exp_q.push_back(e);
        m_pwm = pwm; m_play = play; m_idx = idx; m_done = dn; m_end = t;
    endtask

    // Expected behaviour of a song started at edge t0, played 'passes' times.
    task automatic model_play(input longint t0, input int passes);
        longint t, tn, te, h, n;
        int i, pass, dur, oct, pitch;
        logic pwm;
        t = t0; i = 0; pass = 1;
        emit(t0, 1'b0, 1'b1, 0, 1'b0);
        forever begin
            dur   = int'(ram_img[i][9:6]);
            oct   = int'(ram_img[i][5:4]);
            pitch = int'(ram_img[i][3:0]);
            if (dur == 0) begin
                te = t + 2;
            end else begin
                h = half_ref(pitch) >> oct;
                n = longint'(dur) * BEAT - GAP;
                pwm = 1'b0;
                if (h > 0) begin
                    for (longint k = h; k < n; k += h) begin
                        pwm = ~pwm;
                        emit(t + 1 + k, pwm, 1'b1, i, 1'b0);
                    end
                end
                emit(t + 1 + n, 1'b0, 1'b1, i, 1'b0);
                tn = t + 1 + longint'(dur) * BEAT;
                if (i < DEPTH - 1) begin
                    i++;
                    t = tn;
                    emit(t, 1'b0, 1'b1, i, 1'b0);
                    continue;
                end
                te = tn + 1;
            end
            if (pass < passes) begin
                pass++;
                i = 0;
                t = te;
                emit(t, 1'b0, 1'b1, 0, 1'b0);
            end else begin
                emit(te, 1'b0, 1'b0, i, 1'b1);
                emit(te + 1, 1'b0, 1'b0, i, 1'b0);
                break;
            end
        end
    endtask

    // Monitor: on every change of the output tuple, pop and compare.
    initial begin
        logic [6:0] prev, cur, expv;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {aud_pwm, aud_sd, playing, done, note_idx};
            if (mon_en && cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 1'b0, $sformatf("t=%0d out=%b", cyc, cur), "no change");
                end else begin
                    e = exp_q.pop_front();
                    expv = {e.pwm, e.play, e.play, e.done, e.idx};
                    check("output_event", (e.t == cyc) && (cur === expv),
                          $sformatf("t=%0d out=%b", cyc, cur),
                          $sformatf("t=%0d out=%b", e.t, expv));
                end
            end
            prev = cur;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DUR_W+5:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        ram_img[a] = d;
    endtask

    task automatic start_song(output longint t0);
        start = 1'b1;
        t0 = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_song(input string name);
        while (cyc < m_end + 3) tick();
        check(name, exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
        exp_q.delete();
    endtask

    initial begin
        longint t0, ts, len;
        repeat (3) tick();
        check("reset_pwm",  aud_pwm === 1'b0,  $sformatf("%b", aud_pwm),  "0");
        check("reset_sd",   aud_sd === 1'b0,   $sformatf("%b", aud_sd),   "0");
        check("reset_play", playing === 1'b0,  $sformatf("%b", playing),  "0");
        check("reset_idx",  note_idx === 3'd0, $sformatf("%0d", note_idx), "0");
        check("reset_done", done === 1'b0,     $sformatf("%b", done),     "0");
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // A4, two beats, then the end marker.
        wr(0, ent(2, 0, 10));
        wr(1, ent(0, 0, 0));
        start_song(t0);
        model_play(t0, 1);
        finish_song("a4_song");

        // C4 two octaves up.
        wr(0, ent(1, 2, 1));
        start_song(t0);
        model_play(t0, 1);
        finish_song("c4_oct2_song");

        // Rest note: amplifier on, pin silent.
        wr(0, ent(1, 0, 0));
        start_song(t0);
        model_play(t0, 1);
        while (cyc < t0 + 500) tick();
        check("rest_silent", aud_pwm === 1'b0 && aud_sd === 1'b1,
              $sformatf("pwm=%b sd=%b", aud_pwm, aud_sd), "pwm=0 sd=1");
        finish_song("rest_song");

        // Reset in the middle of a tone, then replay from a fresh start.
        wr(0, ent(2, 0, 10));
        wr(1, ent(0, 0, 0));
        start_song(t0);
        ts = t0 + 500;
        m_cut = ts;
        model_play(t0, 1);
        m_cut = 64'h7fff_ffff_ffff_ffff;
        emit(ts, 1'b0, 1'b0, 0, 1'b0);
        while (cyc < ts - 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_state", {aud_pwm, aud_sd, playing, note_idx} === 6'b0,
              $sformatf("%b", {aud_pwm, aud_sd, playing, note_idx}), "000000");
        finish_song("reset_mid_tone");
        start_song(t0);
        model_play(t0, 1);
        finish_song("replay_after_reset");

        // Stop during the second note keeps note_idx.
        wr(0, ent(1, 1, 5));
        wr(1, ent(1, 0, 8));
        wr(2, ent(0, 0, 0));
        start_song(t0);
        ts = t0 + 1 + BEAT + 300;
        m_cut = ts;
        model_play(t0, 1);
        m_cut = 64'h7fff_ffff_ffff_ffff;
        emit(ts, 1'b0, 1'b0, 1, 1'b0);
        while (cyc < ts - 1) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_idx_held", note_idx === 3'd1 && playing === 1'b0,
              $sformatf("idx=%0d play=%b", note_idx, playing), "idx=1 play=0");
        finish_song("stop_mid_song");

        // start and stop together from IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (5) tick();
        check("start_stop_idle", playing === 1'b0 && aud_sd === 1'b0,
              $sformatf("play=%b sd=%b", playing, aud_sd), "play=0 sd=0");

        // Three random notes looping; a stray start is ignored and
        // loop_en drops during the third pass.
        for (int i = 0; i < 3; i++)
            wr(i, ent(1, int'($urandom_range(0, 3)), int'($urandom_range(1, 12))));
        wr(3, ent(0, 0, 0));
        loop_en = 1'b1;
        start_song(t0);
        model_play(t0, 3);
        len = 3 * (1 + BEAT) + 2;
        while (cyc < t0 + 3000) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t0 + 2 * len + 1000) tick();
        loop_en = 1'b0;
        finish_song("loop_three_passes");

        // Every entry non-zero: playback runs off the last entry into END.
        for (int i = 0; i < DEPTH; i++)
            wr(i, ent(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15))));
        start_song(t0);
        model_play(t0, 1);
        finish_song("full_ram");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
